// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps a,b,c,d over all 16 vectors and captures two 4-input function truth tables.
// Optional STOP_ON_MISMATCH_EN ends the sweep at the first mismatching vector and reports fail_index.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        f0_in,
  input  logic        f1_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] table0,
  output logic [15:0] table1,
  output logic [15:0] mismatch,
  output logic        pass
`ifdef STOP_ON_MISMATCH_EN
  ,
  output logic [3:0]  fail_index
`endif
);
  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;
  state_t state;
  logic [3:0] idx, cnt;
  logic [15:0] exp_q, mm_next;
  logic miss, last;
  assign miss = (f0_in != exp_q[idx]) || (f1_in != exp_q[idx]);
  assign mm_next = mismatch | (16'(miss) << idx);
`ifdef STOP_ON_MISMATCH_EN
  assign last = (idx == 4'd15) || miss;
`else
  assign last = idx == 4'd15;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      {a, b, c, d} <= 4'd0;
      busy <= 1'b0;
      done <= 1'b0;
      table0 <= '0;
      table1 <= '0;
      mismatch <= '0;
      pass <= 1'b0;
      cnt <= '0;
      idx <= '0;
      exp_q <= '0;
`ifdef STOP_ON_MISMATCH_EN
      fail_index <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          exp_q <= expected;
          table0 <= '0;
          table1 <= '0;
          mismatch <= '0;
          pass <= 1'b0;
          idx <= '0;
          cnt <= '0;
          {a, b, c, d} <= 4'd0;
          busy <= 1'b1;
          state <= HOLD;
`ifdef STOP_ON_MISMATCH_EN
          fail_index <= '0;
`endif
        end
        HOLD: if (cnt == 4'(SETTLE_CYCLES - 1)) state <= SAMPLE;
              else cnt <= cnt + 4'd1;
        SAMPLE: begin
          table0[idx] <= f0_in;
          table1[idx] <= f1_in;
          mismatch <= mm_next;
          if (last) begin
            state <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
            pass <= mm_next == 16'd0;
`ifdef STOP_ON_MISMATCH_EN
            fail_index <= miss ? idx : 4'd0;
`endif
          end else begin
            idx <= idx + 4'd1;
            {a, b, c, d} <= idx + 4'd1;
            cnt <= '0;
            state <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed sweeps with a scoreboard of expected results, for SETTLE_CYCLES 1 and 3.
module tb_truth_table_sweeper;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start3 = 1'b0, brk = 1'b0, sel = 1'b0;
  logic [15:0] expected = 16'd0;
  logic [15:0] fn = 16'h3887;
  logic a1, b1, c1, d1, busy1, done1, pass1, f0_1, f1_1;
  logic a3, b3, c3, d3, busy3, done3, pass3, f0_3, f1_3;
  logic [15:0] t0_1, t1_1, mm_1, t0_3, t1_3, mm_3;
  logic [3:0] vec_m;
  logic busy_m, done_m, pass_m;
  logic [15:0] t0_m, t1_m, mm_m;
`ifdef STOP_ON_MISMATCH_EN
  logic [3:0] fi1, fi3, fi_m;
  assign fi_m = sel ? fi3 : fi1;
`endif
  int n_cmp = 0, n_err = 0;

  typedef struct {logic [15:0] t0, t1, mm; logic ps; logic [3:0] fi; int lat;} res_t;
  res_t q[$];

  always #5 clk = ~clk;

  assign f0_1 = fn[{a1, b1, c1, d1}];
  assign f1_1 = f0_1 & ~(brk && {a1, b1, c1, d1} == 4'd7);
  assign f0_3 = fn[{a3, b3, c3, d3}];
  assign f1_3 = f0_3 & ~(brk && {a3, b3, c3, d3} == 4'd7);

  assign vec_m  = sel ? {a3, b3, c3, d3} : {a1, b1, c1, d1};
  assign busy_m = sel ? busy3 : busy1;
  assign done_m = sel ? done3 : done1;
  assign pass_m = sel ? pass3 : pass1;
  assign t0_m   = sel ? t0_3 : t0_1;
  assign t1_m   = sel ? t1_3 : t1_1;
  assign mm_m   = sel ? mm_3 : mm_1;

  truth_table_sweeper #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .expected(expected), .f0_in(f0_1), .f1_in(f1_1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .table0(t0_1), .table1(t1_1), .mismatch(mm_1), .pass(pass1)
`ifdef STOP_ON_MISMATCH_EN
    , .fail_index(fi1)
`endif
  );

  truth_table_sweeper #(.SETTLE_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .expected(expected), .f0_in(f0_3), .f1_in(f1_3),
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
    .table0(t0_3), .table1(t1_3), .mismatch(mm_3), .pass(pass3)
`ifdef STOP_ON_MISMATCH_EN
    , .fail_index(fi3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_vec"}, vec_m, 0);
    chk({tag, "_busy"}, busy_m, 0);
    chk({tag, "_done"}, done_m, 0);
    chk({tag, "_t0"}, t0_m, 0);
    chk({tag, "_t1"}, t1_m, 0);
    chk({tag, "_mm"}, mm_m, 0);
    chk({tag, "_pass"}, pass_m, 0);
`ifdef STOP_ON_MISMATCH_EN
    chk({tag, "_fi"}, fi_m, 0);
`endif
  endtask

  task automatic push_exp(input int s, input logic [15:0] e, input logic bk);
    res_t r;
    r.t0 = fn;
    r.t1 = bk ? (fn & 16'hff7f) : fn;
    r.mm = (r.t0 ^ e) | (r.t1 ^ e);
    r.fi = 4'd0;
    r.lat = 16 * (s + 1);
`ifdef STOP_ON_MISMATCH_EN
    begin
      logic [15:0] keep;
      bit found;
      keep = '0;
      found = 0;
      for (int i = 0; i < 16; i++)
        if (!found) begin
          keep[i] = 1'b1;
          if (r.mm[i]) begin
            found = 1;
            r.fi = i[3:0];
            r.lat = (i + 1) * (s + 1);
          end
        end
      r.t0 &= keep;
      r.t1 &= keep;
      r.mm &= keep;
    end
`endif
    r.ps = r.mm == 16'd0;
    q.push_back(r);
  endtask

  task automatic sweep(input logic s3, input logic [15:0] e, input logic bk, input bit inject, input bit abort);
    int s, n, limit;
    res_t r;
    logic [3:0] hold_vec;
    s = s3 ? 3 : 1;
    limit = 16 * (s + 1) + 8;
    sel = s3;
    brk = bk;
    expected = e;
    @(negedge clk);
    if (s3) start3 = 1'b1; else start = 1'b1;
    push_exp(s, e, bk);
    @(negedge clk);
    start = 1'b0;
    start3 = 1'b0;
    chk("busy_after_start", busy_m, 1);
    chk("pass_cleared", pass_m, 0);
    chk("t0_cleared", t0_m, 0);
    n = 0;
    while (!done_m && n < limit) begin
      chk("vector", vec_m, n / (s + 1));
      if (inject && n == 8) begin start = 1'b1; expected = ~e; end
      if (inject && n == 9) start = 1'b0;
      if (abort && n == 12) begin
        rst = 1'b1;
        #1;
        chk_idle_zero("abort");
        void'(q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        expected = e;
        return;
      end
      @(negedge clk);
      n++;
    end
    r = q.pop_front();
    chk("done_seen", done_m, 1);
    chk("latency", n, r.lat);
    chk("busy_at_done", busy_m, 0);
    chk("table0", t0_m, r.t0);
    chk("table1", t1_m, r.t1);
    chk("mismatch", mm_m, r.mm);
    chk("pass", pass_m, r.ps);
    hold_vec = 4'd15;
`ifdef STOP_ON_MISMATCH_EN
    chk("fail_index", fi_m, r.fi);
    if (r.mm != 16'd0) hold_vec = r.fi;
`endif
    repeat (3) @(negedge clk);
    chk("done_pulse", done_m, 0);
    chk("vec_hold", vec_m, hold_vec);
    chk("table0_hold", t0_m, r.t0);
    chk("pass_hold", pass_m, r.ps);
    expected = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b1;
    start3 = 1'b1;
    repeat (3) @(negedge clk);
    sel = 1'b0; chk_idle_zero("reset1");
    sel = 1'b1; chk_idle_zero("reset3");
    start = 1'b0;
    start3 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    sel = 1'b0; chk_idle_zero("idle1");
    sweep(1'b0, 16'h3887, 1'b0, 1'b0, 1'b0);
    sweep(1'b0, 16'h3887, 1'b1, 1'b0, 1'b0);
    sweep(1'b0, 16'h3887, 1'b0, 1'b1, 1'b0);
    sweep(1'b0, 16'h3887, 1'b0, 1'b0, 1'b1);
    sweep(1'b0, 16'h3887, 1'b0, 1'b0, 1'b0);
    sweep(1'b0, 16'h1234, 1'b0, 1'b0, 1'b0);
    sweep(1'b1, 16'h3887, 1'b0, 1'b0, 1'b0);
    sweep(1'b1, 16'h3887, 1'b1, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
